activation_writer_layer: RTL and testbench

Writes a flat vector of fixed-width words into the shared BRAM at consecutive addresses, one word per cycle. It is the write-side counterpart of the layer parameter loaders: layer outputs are captured on `start`, stored to `BASE_ADDR .. BASE_ADDR+N_WORDS-1`, and `done` is signalled when the store is complete. An optional read-back pass checks the stored data and flags mismatches.

---
 rtl/nn_mem_pkg.sv | 23 ++
 rtl/BRAM.sv | 27 ++
 rtl/activation_writer_layer.sv | 163 ++++++++++++++++
 tb/tb_activation_writer_layer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_mem_pkg.sv
// Shared memory-map and FSM definitions for the layer loaders and writers.
// Consumers may be built with ACT_WRITER_VERIFY_EN to enable read-back checking.
package nn_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_VERIFY = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int BRAM_READ_LATENCY  = 2;
  localparam int DEFAULT_W          = 8;
  localparam int DEFAULT_ADDR_WIDTH = 15;

  // Layer regions inside the shared BRAM.
  localparam int L1_WEIGHT_BASE = 0;
  localparam int L1_BIAS_BASE   = 16384;
  localparam int L2_WEIGHT_BASE = 16448;
  localparam int ACT_BASE_ADDR  = 17098;

endpackage

// File: rtl/BRAM.sv
// Single-port block RAM: synchronous write, LATENCY-cycle registered read.
module BRAM #(
  parameter int W          = 8,
  parameter int ADDR_WIDTH = 15,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  wen,
  input  logic                  ren,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [W-1:0]          din,
  output logic [W-1:0]          dout
);

  logic [W-1:0] mem  [2**ADDR_WIDTH];
  logic [W-1:0] pipe [LATENCY];

  always_ff @(posedge clk) begin
    if (en && wen) mem[addr] <= din;
    if (en && ren) pipe[0] <= mem[addr];
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end

  assign dout = pipe[LATENCY-1];

endmodule

// File: rtl/activation_writer_layer.sv
// Captures a flat activation vector on start and stores it word by word into BRAM.
// Define ACT_WRITER_VERIFY_EN to add a read-back pass that drives mismatch.
module activation_writer_layer
  import nn_mem_pkg::*;
#(
  parameter int N_WORDS    = 10,
  parameter int W          = DEFAULT_W,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int BASE_ADDR  = ACT_BASE_ADDR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_WORDS*W-1:0] data_in,
  output logic                 busy,
  output logic                 done,
  output logic                 mismatch
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int SEL_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [CNT_W-1:0]      LAST_IDX   = CNT_W'(N_WORDS - 1);
  localparam logic [CNT_W-1:0]      DRAIN_LAST = CNT_W'(BRAM_READ_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(BASE_ADDR);

  if (BASE_ADDR + N_WORDS - 1 >= 2**ADDR_WIDTH) begin : g_range_check
    $error("activation_writer_layer: BASE_ADDR+N_WORDS-1 exceeds the BRAM address space");
  end

  // Protocol: start is a request honoured only in IDLE or DONE; busy covers the
  // whole store (and read-back), done is a level that holds until the next start.
  state_t                  state, state_next;
  logic [CNT_W-1:0]        idx;
  logic [W-1:0]            shadow [N_WORDS];
  logic                    accept;
  logic                    fsm_wen;
  logic [ADDR_WIDTH-1:0]   fsm_addr;
  logic [W-1:0]            cur_word;
  logic                    bram_en, bram_wen, bram_ren;
  logic [ADDR_WIDTH-1:0]   bram_addr;
  logic [W-1:0]            bram_din, bram_dout;

  assign accept = start && (state == ST_IDLE || state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_next = ST_WRITE;
      ST_WRITE: if (idx == LAST_IDX) begin
`ifdef ACT_WRITER_VERIFY_EN
        state_next = ST_VERIFY;
`else
        state_next = ST_DONE;
`endif
      end
      ST_VERIFY: if (idx == LAST_IDX)   state_next = ST_DRAIN;
      ST_DRAIN:  if (idx == DRAIN_LAST) state_next = ST_DONE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // idx restarts at every state change, so it serves as word, read and drain counter.
  always_ff @(posedge clk) begin
    if (rst || state_next != state) idx <= '0;
    else if (state == ST_WRITE || state == ST_VERIFY || state == ST_DRAIN) idx <= idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_WORDS; i++) shadow[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < N_WORDS; i++) shadow[i] <= data_in[i*W +: W];
    end
  end

  always_comb begin
    fsm_wen  = (state == ST_WRITE);
    fsm_addr = BASE + idx[ADDR_WIDTH-1:0];
    cur_word = (idx <= LAST_IDX) ? shadow[idx[SEL_W-1:0]] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state == ST_WRITE || state == ST_VERIFY || state == ST_DRAIN);
      done <= (state == ST_DONE) && !start;
    end
  end

`ifdef ACT_WRITER_VERIFY_EN
  // Read requests are registered, so each read reaches the BRAM one cycle after VERIFY issues it.
  logic                         rd_req_q;
  logic [ADDR_WIDTH-1:0]        rd_addr_q;
  logic [SEL_W-1:0]             rd_sel_q;
  logic [BRAM_READ_LATENCY-1:0] tag_v;
  logic [SEL_W-1:0]             tag_sel [BRAM_READ_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_req_q  <= 1'b0;
      rd_addr_q <= BASE;
      rd_sel_q  <= '0;
      for (int i = 0; i < BRAM_READ_LATENCY; i++) begin
        tag_v[i]   <= 1'b0;
        tag_sel[i] <= '0;
      end
    end else begin
      rd_req_q   <= (state == ST_VERIFY);
      rd_addr_q  <= fsm_addr;
      rd_sel_q   <= idx[SEL_W-1:0];
      tag_v[0]   <= rd_req_q;
      tag_sel[0] <= rd_sel_q;
      for (int i = 1; i < BRAM_READ_LATENCY; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_sel[i] <= tag_sel[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || accept) mismatch <= 1'b0;
    else if (tag_v[BRAM_READ_LATENCY-1] &&
             bram_dout != shadow[tag_sel[BRAM_READ_LATENCY-1]]) mismatch <= 1'b1;
  end

  assign bram_en   = (fsm_wen || rd_req_q) && !rst;
  assign bram_ren  = rd_req_q && !rst;
  assign bram_addr = rd_req_q ? rd_addr_q : fsm_addr;
`else
  logic unused_dout;
  assign unused_dout = ^bram_dout;
  assign mismatch    = 1'b0;
  assign bram_en     = fsm_wen && !rst;
  assign bram_ren    = 1'b0;
  assign bram_addr   = fsm_addr;
`endif

  // Reset gates the write strobe combinationally so a mid-store reset blocks that edge's write.
  assign bram_wen = fsm_wen && !rst;
  assign bram_din = cur_word;

  BRAM #(
    .W          (W),
    .ADDR_WIDTH (ADDR_WIDTH),
    .LATENCY    (BRAM_READ_LATENCY)
  ) u_bram (
    .clk  (clk),
    .en   (bram_en),
    .wen  (bram_wen),
    .ren  (bram_ren),
    .addr (bram_addr),
    .din  (bram_din),
    .dout (bram_dout)
  );

endmodule

// File: tb/tb_activation_writer_layer.sv
// Bench for activation_writer_layer: write scoreboard, memory model and done/busy timing.
module tb_activation_writer_layer;
  import nn_mem_pkg::*;

  localparam int N    = 10;
  localparam int W    = 8;
  localparam int AW   = 15;
  localparam int BASE = 17098;
  localparam int EW   = 32 + AW + W;
`ifdef ACT_WRITER_VERIFY_EN
  localparam int DONE_LAT  = 2*N + 3;
  localparam int DONE_LAT1 = 5;
`else
  localparam int DONE_LAT  = N + 1;
  localparam int DONE_LAT1 = 2;
`endif

  logic           clk = 1'b0;
  logic           rst, start, start1;
  logic [N*W-1:0] data_in;
  logic [W-1:0]   data1;
  logic           busy, done, mismatch, busy1, done1, mismatch1;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  model_mem [int];
  logic [EW-1:0] mon_got, mon_want;

  activation_writer_layer #(.N_WORDS(N), .W(W), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .busy(busy), .done(done), .mismatch(mismatch)
  );

  activation_writer_layer #(.N_WORDS(1), .W(W), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .data_in(data1),
    .busy(busy1), .done(done1), .mismatch(mismatch1)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    n_checks++;
    $display("FAIL watchdog: run time limit expired");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // ---------------- scoreboard: every BRAM write, in order, at its edge ----------------
  always @(negedge clk) begin
    if (dut.bram_en && dut.bram_wen) begin
      mon_got = {32'(cyc + 1), dut.bram_addr, dut.bram_din};
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL write_unexpected got edge=%0d addr=%0d data=%h required=no write",
                 cyc + 1, dut.bram_addr, dut.bram_din);
      end else begin
        mon_want = exp_q.pop_front();
        if (mon_got !== mon_want)
          $display("FAIL write_seq got edge=%0d addr=%0d data=%h required edge=%0d addr=%0d data=%h",
                   mon_got[EW-1 -: 32], mon_got[AW+W-1 -: AW], mon_got[W-1:0],
                   mon_want[EW-1 -: 32], mon_want[AW+W-1 -: AW], mon_want[W-1:0]);
        else n_pass++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic to_drive();
    @(posedge clk); #1;
  endtask

  task automatic wait_to(input int t);
    @(negedge clk);
    while (int'(cyc) < t) @(negedge clk);
  endtask

  // Reference model: words land at BASE+i on edge e+i+1 for the first n_write words.
  task automatic drive_start(input logic [N*W-1:0] words, input int n_write, input int hold,
                             output int e);
    e = int'(cyc) + 1;
    start   = 1'b1;
    data_in = words;
    for (int i = 0; i < n_write; i++) begin
      exp_q.push_back({32'(e + i + 1), AW'(BASE + i), words[i*W +: W]});
      model_mem[BASE + i] = words[i*W +: W];
    end
    repeat (hold) @(posedge clk);
    #1 start = 1'b0;
  endtask

  function automatic logic [N*W-1:0] rand_words();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom_range(1, 255));
    return v;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start1 = 1'b0; data_in = '0; data1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({busy, done, mismatch} !== 3'b000) $display("FAIL reset_outputs got=%b required=000", {busy, done, mismatch}); else n_pass++;
    n_checks++; if ({dut.bram_en, dut.bram_wen, dut.bram_ren} !== 3'b000) $display("FAIL reset_enables got=%b required=000", {dut.bram_en, dut.bram_wen, dut.bram_ren}); else n_pass++;
    n_checks++; if (dut.bram_addr !== AW'(BASE)) $display("FAIL reset_addr got=%0d required=%0d", dut.bram_addr, BASE); else n_pass++;
    n_checks++; if ({busy1, done1, mismatch1} !== 3'b000) $display("FAIL reset_outputs_n1 got=%b required=000", {busy1, done1, mismatch1}); else n_pass++;
    to_drive();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [N*W-1:0] w;
    int e;
    for (int i = 0; i < N; i++) w[i*W +: W] = W'(i + 1);
    to_drive();
    drive_start(w, N, 1, e);
    wait_to(e);
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_accept got=%b required=0", busy); else n_pass++;
    wait_to(e + 1);
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy_first got=%b required=1", busy); else n_pass++;
    wait_to(e + DONE_LAT - 1);
    n_checks++; if ({busy, done} !== 2'b10) $display("FAIL basic_before_done got busy,done=%b required=10", {busy, done}); else n_pass++;
    wait_to(e + DONE_LAT);
    n_checks++; if ({busy, done, mismatch} !== 3'b010) $display("FAIL basic_done got busy,done,mismatch=%b required=010", {busy, done, mismatch}); else n_pass++;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (dut.u_bram.mem[BASE + i] !== W'(i + 1)) $display("FAIL basic_readback addr=%0d got=%h required=%h", BASE + i, dut.u_bram.mem[BASE + i], W'(i + 1)); else n_pass++;
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL basic_writes_left got=%0d required=0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_capture();
    int e;
    to_drive();
    drive_start(rand_words(), N, 1, e);
    data_in = '1;
    wait_to(e + DONE_LAT);
    n_checks++; if (done !== 1'b1) $display("FAIL capture_done got=%b required=1", done); else n_pass++;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (dut.u_bram.mem[BASE + i] !== model_mem[BASE + i]) $display("FAIL capture_readback addr=%0d got=%h required=%h", BASE + i, dut.u_bram.mem[BASE + i], model_mem[BASE + i]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int e, e2;
    to_drive();
    drive_start(rand_words(), N, 5, e);
    wait_to(e + DONE_LAT);
    n_checks++; if (done !== 1'b1) $display("FAIL held_start_done got=%b required=1", done); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL held_start_writes_left got=%0d required=0", exp_q.size()); else n_pass++;
    repeat ($urandom_range(1, 3)) @(posedge clk);
    to_drive();
    drive_start(rand_words(), N, 1, e2);
    wait_to(e2);
    n_checks++; if (done !== 1'b0) $display("FAIL restart_done_falls got=%b required=0", done); else n_pass++;
    wait_to(e2 + DONE_LAT - 1);
    n_checks++; if (done !== 1'b0) $display("FAIL restart_done_early got=%b required=0", done); else n_pass++;
    wait_to(e2 + DONE_LAT);
    n_checks++; if (done !== 1'b1) $display("FAIL restart_done_rises got=%b required=1", done); else n_pass++;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (dut.u_bram.mem[BASE + i] !== model_mem[BASE + i]) $display("FAIL restart_readback addr=%0d got=%h required=%h", BASE + i, dut.u_bram.mem[BASE + i], model_mem[BASE + i]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int e;
    to_drive();
    drive_start(rand_words(), 3, 1, e);
    wait_to(e + 2);
    to_drive();
    rst = 1'b1;
    wait_to(e + 4);
    n_checks++; if ({dut.bram_en, dut.bram_wen} !== 2'b00) $display("FAIL rst_mid_enables got=%b required=00", {dut.bram_en, dut.bram_wen}); else n_pass++;
    n_checks++; if ({busy, done, mismatch} !== 3'b000) $display("FAIL rst_mid_outputs got=%b required=000", {busy, done, mismatch}); else n_pass++;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (dut.u_bram.mem[BASE + i] !== model_mem[BASE + i]) $display("FAIL rst_mid_partial addr=%0d got=%h required=%h", BASE + i, dut.u_bram.mem[BASE + i], model_mem[BASE + i]); else n_pass++;
    end
    to_drive();
    rst = 1'b0;
    to_drive();
    drive_start(rand_words(), N, 1, e);
    wait_to(e + DONE_LAT);
    n_checks++; if (done !== 1'b1) $display("FAIL rst_mid_recover_done got=%b required=1", done); else n_pass++;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (dut.u_bram.mem[BASE + i] !== model_mem[BASE + i]) $display("FAIL rst_mid_recover addr=%0d got=%h required=%h", BASE + i, dut.u_bram.mem[BASE + i], model_mem[BASE + i]); else n_pass++;
    end
  endtask

  task automatic test_single_word();
    int e;
    logic [W-1:0] v;
    v = W'($urandom_range(1, 255));
    to_drive();
    e = int'(cyc) + 1;
    start1 = 1'b1;
    data1  = v;
    to_drive();
    start1 = 1'b0;
    data1  = ~v;
    wait_to(e);
    n_checks++; if ({dut1.bram_wen, dut1.bram_addr, dut1.bram_din} !== {1'b1, AW'(BASE), v})
      $display("FAIL single_write got wen=%b addr=%0d data=%h required wen=1 addr=%0d data=%h", dut1.bram_wen, dut1.bram_addr, dut1.bram_din, BASE, v); else n_pass++;
    wait_to(e + DONE_LAT1 - 1);
    n_checks++; if (done1 !== 1'b0) $display("FAIL single_done_early got=%b required=0", done1); else n_pass++;
    wait_to(e + DONE_LAT1);
    n_checks++; if ({busy1, done1} !== 2'b01) $display("FAIL single_done got busy,done=%b required=01", {busy1, done1}); else n_pass++;
    n_checks++; if (dut1.u_bram.mem[BASE] !== v) $display("FAIL single_readback got=%h required=%h", dut1.u_bram.mem[BASE], v); else n_pass++;
  endtask

  task automatic test_random();
    int e;
    for (int t = 0; t < 4; t++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      to_drive();
      drive_start(rand_words(), N, $urandom_range(1, 3), e);
      wait_to(e + DONE_LAT);
      n_checks++; if ({busy, done, mismatch} !== 3'b010) $display("FAIL random_done t=%0d got=%b required=010", t, {busy, done, mismatch}); else n_pass++;
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (dut.u_bram.mem[BASE + i] !== model_mem[BASE + i]) $display("FAIL random_readback t=%0d addr=%0d got=%h required=%h", t, BASE + i, dut.u_bram.mem[BASE + i], model_mem[BASE + i]); else n_pass++;
      end
    end
  endtask

`ifdef ACT_WRITER_VERIFY_EN
  task automatic test_verify_mismatch();
    int e;
    to_drive();
    drive_start(rand_words(), N, 1, e);
    wait_to(e + N + 4);
    to_drive();
    force dut.bram_dout = '0;
    to_drive();
    release dut.bram_dout;
    wait_to(e + DONE_LAT - 1);
    n_checks++; if (done !== 1'b0) $display("FAIL verify_done_early got=%b required=0", done); else n_pass++;
    wait_to(e + DONE_LAT);
    n_checks++; if ({done, mismatch} !== 2'b11) $display("FAIL verify_mismatch got done,mismatch=%b required=11", {done, mismatch}); else n_pass++;
    to_drive();
    drive_start(rand_words(), N, 1, e);
    wait_to(e);
    n_checks++; if (mismatch !== 1'b0) $display("FAIL verify_clear_on_start got=%b required=0", mismatch); else n_pass++;
    wait_to(e + DONE_LAT);
    n_checks++; if ({done, mismatch} !== 2'b10) $display("FAIL verify_clean got done,mismatch=%b required=10", {done, mismatch}); else n_pass++;
  endtask
`endif

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_basic();
    test_capture();
    test_back_to_back();
    test_reset_mid();
    test_single_word();
    test_random();
`ifdef ACT_WRITER_VERIFY_EN
    test_verify_mismatch();
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (exp_q.size() != 0) $display("FAIL final_writes_left got=%0d required=0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
